alu_result_collector: RTL

- Downstream stage of the ALU stimulus driver. Sits on the ALU's start/done/result outputs.
- Captures each completed result and packs NUM_RESULTS 16-bit results into one wide batch word. Slot 0 sits in the LSBs, which mirrors the packing of the stimulus word.
- Presents the batch to the testbench reader with a valid/ready handshake.
- Flags lost results, timeouts and spurious done pulses.

---
 rtl/alu_res_pkg.sv | 26 ++
 rtl/alu_res_lat_tracker.sv | 53 +++++
 rtl/alu_result_collector.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_res_pkg.sv
// rtl/alu_res_pkg.sv - shared types and constants for the ALU result collector
// Contents: collector state enum, result/latency widths, ALU op-code type
// shared with the stimulus driver.
package alu_res_pkg;

  localparam int RES_W = 16;
  localparam int LAT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    HOLD
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SHL,
    OP_SHR,
    OP_PASS
  } alu_op_e;

endpackage

// File: rtl/alu_res_lat_tracker.sv
// rtl/alu_res_lat_tracker.sv - start-to-done latency counter, max register and timeout compare
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   start_acc_i        collector accepted a start this cycle (IDLE -> WAIT_DONE)
//   wait_i             collector is in WAIT_DONE
//   done_i             done accepted in WAIT_DONE this cycle
//   timeout_hit_o      command has reached TIMEOUT without a done this cycle
//   lat_max_o          largest latency seen on an accepted done
module alu_res_lat_tracker
  import alu_res_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_acc_i,
  input  logic             wait_i,
  input  logic             done_i,
  output logic             timeout_hit_o,
  output logic [LAT_W-1:0] lat_max_o
);

  localparam logic [LAT_W-1:0] LAT_SAT = '1;
  localparam logic [LAT_W-1:0] LAT_TO  = LAT_W'(TIMEOUT);

  logic [LAT_W-1:0] lat_cnt_q;
  logic [LAT_W-1:0] lat_max_q;

  // The start cycle itself loads 1, so a done in the very next cycle reads
  // as latency 1.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lat_cnt_q <= '0;
    end else if (start_acc_i) begin
      lat_cnt_q <= LAT_W'(1);
    end else if (wait_i && lat_cnt_q != LAT_SAT) begin
      lat_cnt_q <= lat_cnt_q + LAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lat_max_q <= '0;
    end else if (done_i && lat_cnt_q > lat_max_q) begin
      lat_max_q <= lat_cnt_q;
    end
  end

  // A done in the timeout cycle wins, so it masks the hit.
  assign timeout_hit_o = wait_i && !done_i && (lat_cnt_q == LAT_TO);
  assign lat_max_o     = lat_max_q;

endmodule

// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - packs ALU results into batches with valid/ready readout
// Optional feature macro: ALU_RES_LATENCY_EN (latency tracking and timeout).
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   start_i            ALU start level; done_i one-cycle done pulse; result_i
//   flush_i            emit the partial batch held so far
//   rd_ready_i         reader accepts the presented batch
//   batch_valid_o      batch presented (HOLD); batch_data_o slot 0 in LSBs
//   batch_count_o      number of filled slots
//   busy_o             command in flight (WAIT_DONE)
//   overflow_o         sticky, done while HOLD
//   timeout_o          sticky, command abandoned after TIMEOUT cycles
//   spurious_o         sticky, done while IDLE
//   lat_max_o          maximum observed start-to-done latency
module alu_result_collector #(
  parameter int NUM_RESULTS = 20,
  parameter int RES_W       = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic                               done_i,
  input  logic [RES_W-1:0]                   result_i,
  input  logic                               flush_i,
  input  logic                               rd_ready_i,
  output logic                               batch_valid_o,
  output logic [NUM_RESULTS*RES_W-1:0]       batch_data_o,
  output logic [$clog2(NUM_RESULTS+1)-1:0]   batch_count_o,
  output logic                               busy_o,
  output logic                               overflow_o,
  output logic                               timeout_o,
  output logic                               spurious_o,
  output logic [7:0]                         lat_max_o
);

  import alu_res_pkg::*;

  localparam int DATA_W = NUM_RESULTS * RES_W;
  localparam int CNT_W  = $clog2(NUM_RESULTS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_RESULTS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               spurious_q, spurious_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic               start_acc;
  logic               done_acc;
  logic               timeout_hit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      spurious_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      spurious_q <= spurious_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    spurious_d = spurious_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    start_acc  = 1'b0;
    done_acc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (done_i) begin
          spurious_d = 1'b1;
        end
        // A pending flush takes precedence; the start is seen again from
        // IDLE after the batch has been read.
        if (flush_i && idx_q != '0) begin
          state_d = HOLD;
        end else if (start_i) begin
          state_d   = WAIT_DONE;
          start_acc = 1'b1;
        end
      end

      WAIT_DONE: begin
        if (done_i) begin
          done_acc = 1'b1;
          // Slots above idx are always zero here, so OR-ing in is a write.
          data_d   = data_q | (DATA_W'(result_i) << (RES_W * int'(idx_q)));
          idx_d    = idx_q + CNT_W'(1);
          if (idx_d == CNT_FULL || flush_i) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (flush_i && idx_q != '0) begin
          state_d = HOLD;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end

      HOLD: begin
        if (done_i) begin
          overflow_d = 1'b1;
        end
        if (rd_ready_i) begin
          state_d = IDLE;
          idx_d   = '0;
          data_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ALU_RES_LATENCY_EN
  alu_res_lat_tracker #(
    .TIMEOUT(TIMEOUT)
  ) u_lat_tracker (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_acc_i  (start_acc),
    .wait_i       (state_q == WAIT_DONE),
    .done_i       (done_acc),
    .timeout_hit_o(timeout_hit),
    .lat_max_o    (lat_max_o)
  );
`else
  logic unused_lat;
  assign unused_lat  = start_acc | done_acc | (TIMEOUT == 0);
  assign timeout_hit = 1'b0;
  assign lat_max_o   = '0;
`endif

  assign batch_valid_o = (state_q == HOLD);
  assign busy_o        = (state_q == WAIT_DONE);
  assign batch_data_o  = data_q;
  assign batch_count_o = idx_q;
  assign overflow_o    = overflow_q;
  assign timeout_o     = timeout_q;
  assign spurious_o    = spurious_q;

endmodule
